// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - memory-side bus of mem_access_ctrl
interface mem_access_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - EX/MEM load/store access controller with wait-state timeout
// Optional ALIGN_CHECK_EN: misaligned word accesses fault without touching memory.
module mem_access_ctrl (
  input  logic               CLK,
  input  logic               CLR_N,
  input  logic               enable_i,
  input  logic               rw_i,
  input  logic               size_i,
  input  logic               load_i,
  input  logic               rf_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  mem_access_ctrl_if.master  mem,
  output logic               stall_o,
  output logic               valid_o,
  output logic [31:0]        rdata_o,
  output logic               load_o,
  output logic               rf_o,
  output logic               err_o,
  output logic               fault_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        rw_q, size_q, load_q, rf_q;
  logic [31:0] addr_q, wdata_q;
  logic        req_q, valid_q, err_q, fault_q, load_out_q, rf_out_q;
  logic [31:0] rdata_q;
  logic [7:0]  lane_d;
  logic [31:0] rdata_d;
  logic        misalign_w;

`ifdef ALIGN_CHECK_EN
  assign misalign_w = ~size_i & (addr_i[1:0] != 2'b00);
`else
  assign misalign_w = 1'b0;
`endif

  always_comb begin
    lane_d  = 8'h00;
    rdata_d = '0;
    case (addr_q[1:0])
      2'd0: lane_d = mem.mem_rdata_i[7:0];
      2'd1: lane_d = mem.mem_rdata_i[15:8];
      2'd2: lane_d = mem.mem_rdata_i[23:16];
      default: lane_d = mem.mem_rdata_i[31:24];
    endcase
    if (rw_q)
      rdata_d = '0;
    else if (size_q)
      rdata_d = {24'h000000, lane_d};
    else
      rdata_d = mem.mem_rdata_i;
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      size_q     <= 1'b0;
      load_q     <= 1'b0;
      rf_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      fault_q    <= 1'b0;
      load_out_q <= 1'b0;
      rf_out_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // Response outputs are one-cycle pulses unless re-armed below.
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      fault_q    <= 1'b0;
      load_out_q <= 1'b0;
      rf_out_q   <= 1'b0;
      rdata_q    <= '0;
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            rw_q    <= rw_i;
            size_q  <= size_i;
            load_q  <= load_i;
            rf_q    <= rf_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= '0;
            if (misalign_w) begin
              state_q    <= RESP;
              valid_q    <= 1'b1;
              fault_q    <= 1'b1;
              load_out_q <= load_i;
              rf_out_q   <= rf_i;
            end else begin
              state_q <= BUSY;
              req_q   <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Ack wins over a timeout landing on the same cycle.
          if (mem.mem_ack_i) begin
            state_q    <= RESP;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            rdata_q    <= rdata_d;
            load_out_q <= load_q;
            rf_out_q   <= rf_q;
          end else if (cnt_q == 8'hFF) begin
            state_q    <= RESP;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            err_q      <= 1'b1;
            load_out_q <= load_q;
            rf_out_q   <= rf_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = req_q & rw_q;
  assign mem.mem_addr_o  = req_q ? {addr_q[31:2], 2'b00} : '0;
  assign mem.mem_be_o    = !req_q ? 4'b0000 : (size_q ? (4'b0001 << addr_q[1:0]) : 4'b1111);
  assign mem.mem_wdata_o = !req_q ? '0 : (size_q ? {4{wdata_q[7:0]}} : wdata_q);

  assign stall_o = CLR_N & (((state_q == IDLE) & enable_i) | (state_q == BUSY));
  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign load_o  = load_out_q;
  assign rf_o    = rf_out_q;
  assign err_o   = err_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - transaction-level model and per-cycle compare for mem_access_ctrl
module tb_mem_access_ctrl;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        CLR_N;
  logic        enable_i, rw_i, size_i, load_i, rf_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, valid_o, load_o, rf_o, err_o, fault_o;
  logic [31:0] rdata_o;

  mem_access_ctrl_if mem ();

  mem_access_ctrl dut (
    .CLK(CLK), .CLR_N(CLR_N), .enable_i(enable_i), .rw_i(rw_i), .size_i(size_i),
    .load_i(load_i), .rf_i(rf_i), .addr_i(addr_i), .wdata_i(wdata_i), .mem(mem),
    .stall_o(stall_o), .valid_o(valid_o), .rdata_o(rdata_o), .load_o(load_o),
    .rf_o(rf_o), .err_o(err_o), .fault_o(fault_o)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic        chk_en = 1'b0;
  logic        exp_all, exp_stall_x;
  logic        exp_stall, exp_req, exp_we, exp_valid, exp_err, exp_fault, exp_load, exp_rf;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  int          cyc = 0;
  int          start_cyc;
  int          stall_cnt = 0, valid_cnt = 0, req_cnt = 0;
  int          cap_valid_cyc = 0;
  logic [31:0] cap_rdata = '0, cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0, cap_err = 1'b0, cap_fault = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      if (!exp_stall_x) check("stall_o", {31'b0, stall_o}, {31'b0, exp_stall});
      check("mem_req_o", {31'b0, mem.mem_req_o}, {31'b0, exp_req});
      check("mem_we_o", {31'b0, mem.mem_we_o}, {31'b0, exp_we});
      check("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
      check("err_o", {31'b0, err_o}, {31'b0, exp_err});
      check("fault_o", {31'b0, fault_o}, {31'b0, exp_fault});
      if (exp_req || exp_all) begin
        check("mem_addr_o", mem.mem_addr_o, exp_addr);
        check("mem_be_o", {28'b0, mem.mem_be_o}, {28'b0, exp_be});
        check("mem_wdata_o", mem.mem_wdata_o, exp_wdata);
      end
      if (exp_valid || exp_all) begin
        check("rdata_o", rdata_o, exp_rdata);
        check("load_o", {31'b0, load_o}, {31'b0, exp_load});
        check("rf_o", {31'b0, rf_o}, {31'b0, exp_rf});
      end
    end
    if (stall_o === 1'b1) stall_cnt++;
    if (valid_o === 1'b1) begin
      valid_cnt++;
      cap_valid_cyc = cyc;
      cap_rdata = rdata_o;
      cap_err = err_o;
      cap_fault = fault_o;
    end
    if (mem.mem_req_o === 1'b1) begin
      req_cnt++;
      cap_addr = mem.mem_addr_o;
      cap_be = mem.mem_be_o;
      cap_wdata = mem.mem_wdata_o;
      cap_we = mem.mem_we_o;
    end
    cyc++;
  end

  task automatic set_idle_exp();
    exp_all = 1'b0; exp_stall_x = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_valid = 1'b0;
    exp_err = 1'b0; exp_fault = 1'b0; exp_load = 1'b0; exp_rf = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_be = '0;
  endtask

  task automatic scramble_inputs();
    rw_i = 1'($urandom); size_i = 1'($urandom); load_i = 1'($urandom); rf_i = 1'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
    mem.mem_ack_i = 1'($urandom); mem.mem_rdata_i = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      scramble_inputs();
      enable_i = 1'b0;
      set_idle_exp();
    end
  endtask

  // dly: BUSY cycle index carrying the ack, >255 means no ack. rst_at: BUSY index to reset in, -1 none.
  task automatic txn(input logic rw, input logic sz, input logic [31:0] a, input logic [31:0] wd,
                     input logic ld, input logic rf, input int dly, input int rst_at,
                     input logic [31:0] rd);
    logic       mis;
    int         nb;
    int         sh;
    logic [3:0] be;
    mis = ALIGN_ON && !sz && (a[1:0] != 2'b00);
    sh  = int'(a[1:0]);
    be  = sz ? 4'(1 << sh) : 4'hF;
    @(posedge CLK); #1;
    start_cyc = cyc;
    scramble_inputs();
    enable_i = 1'b1; rw_i = rw; size_i = sz; addr_i = a; wdata_i = wd; load_i = ld; rf_i = rf;
    set_idle_exp();
    exp_stall = 1'b1;
    if (!mis) begin
      nb = (dly <= 255) ? dly + 1 : 256;
      for (int i = 0; i < nb; i++) begin
        @(posedge CLK); #1;
        scramble_inputs();
        enable_i = 1'($urandom);
        mem.mem_ack_i = (i == dly);
        mem.mem_rdata_i = (i == dly) ? rd : $urandom;
        set_idle_exp();
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = rw;
        exp_addr = {a[31:2], 2'b00}; exp_be = be;
        exp_wdata = sz ? {4{wd[7:0]}} : wd;
        if (i == rst_at) begin
          CLR_N = 1'b0;
          exp_stall_x = 1'b1;
          @(posedge CLK); #1;
          CLR_N = 1'b1;
          scramble_inputs();
          enable_i = 1'b0;
          set_idle_exp();
          exp_all = 1'b1;
          return;
        end
      end
    end
    @(posedge CLK); #1;
    scramble_inputs();
    enable_i = 1'b0;
    set_idle_exp();
    exp_valid = 1'b1;
    exp_err   = !mis && (dly > 255);
    exp_fault = mis;
    exp_load  = ld;
    exp_rf    = rf;
    if (mis || exp_err || rw) exp_rdata = '0;
    else if (sz) exp_rdata = (rd >> (8 * sh)) & 32'h0000_00FF;
    else exp_rdata = rd;
  endtask

  int s0, v0, r0;

  initial begin
    CLR_N = 1'b0; enable_i = 1'b0; rw_i = 1'b0; size_i = 1'b0; load_i = 1'b0; rf_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem.mem_ack_i = 1'b0; mem.mem_rdata_i = '0;
    set_idle_exp();
    @(posedge CLK); #1;
    exp_all = 1'b1; chk_en = 1'b1;
    @(posedge CLK); #1;
    CLR_N = 1'b1;
    idle(2);

    txn(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b1, 1'b0, 0, -1, 32'hDEAD_BEEF);
    idle(1);
    check("word_rd_latency", 32'(cap_valid_cyc - start_cyc), 32'd2);
    check("word_rd_rdata", cap_rdata, 32'hDEAD_BEEF);
    check("word_rd_be", {28'b0, cap_be}, 32'h0000_000F);
    check("word_rd_addr", cap_addr, 32'h0000_0104);

    txn(1'b1, 1'b1, 32'h0000_0203, 32'h1234_5678, 1'b0, 1'b0, 2, -1, $urandom);
    idle(1);
    check("byte_wr_be", {28'b0, cap_be}, 32'h0000_0008);
    check("byte_wr_wdata", cap_wdata, 32'h7878_7878);
    check("byte_wr_we", {31'b0, cap_we}, 32'd1);
    check("byte_wr_rdata", cap_rdata, 32'h0);

    s0 = stall_cnt;
    txn(1'b0, 1'b1, 32'h0000_0002, 32'h0, 1'b1, 1'b1, 4, -1, 32'hAABB_CCDD);
    idle(1);
    check("byte_rd_rdata", cap_rdata, 32'h0000_00BB);
    check("byte_rd_stall_cycles", 32'(stall_cnt - s0), 32'd6);

    txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 1000, -1, 32'h0);
    idle(1);
    check("timeout_err", {31'b0, cap_err}, 32'd1);
    check("timeout_latency", 32'(cap_valid_cyc - start_cyc), 32'd257);
    check("timeout_rdata", cap_rdata, 32'h0);

    txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 1'b0, 255, -1, 32'h5A5A_1234);
    idle(1);
    check("ack255_err", {31'b0, cap_err}, 32'd0);
    check("ack255_latency", 32'(cap_valid_cyc - start_cyc), 32'd257);
    check("ack255_rdata", cap_rdata, 32'h5A5A_1234);

    v0 = valid_cnt;
    txn(1'b0, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 1'b1, 10, 3, 32'h1111_2222);
    idle(3);
    check("reset_busy_no_valid", 32'(valid_cnt - v0), 32'd0);

    r0 = req_cnt;
    txn(1'b0, 1'b0, 32'h0000_0101, 32'h0, 1'b0, 1'b0, 0, -1, 32'hCAFE_F00D);
    idle(1);
`ifdef ALIGN_CHECK_EN
    check("align_fault", {31'b0, cap_fault}, 32'd1);
    check("align_no_req", 32'(req_cnt - r0), 32'd0);
    check("align_rdata", cap_rdata, 32'h0);
`else
    check("unaligned_word_addr", cap_addr, 32'h0000_0100);
    check("unaligned_word_rdata", cap_rdata, 32'hCAFE_F00D);
    check("unaligned_word_fault", {31'b0, cap_fault}, 32'd0);
`endif

    for (int t = 0; t < 60; t++) begin
      txn(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) == 0) ? 255 + int'($urandom_range(0, 1)) * 100 : int'($urandom_range(0, 5)),
          ($urandom_range(0, 11) == 0) ? 0 : -1, $urandom);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
